// File: rtl/ram_sync_paged_pkg.sv
// Shared defaults and state encoding for the paged synchronous RAM.
package ram_sync_paged_pkg;

  localparam int unsigned DefaultDataW = 4;
  localparam int unsigned DefaultPageW = 4;
  localparam int unsigned DefaultOffsW = 8;

  localparam logic [DefaultDataW-1:0] DefaultClearVal = '0;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } ram_state_e;

endpackage

// File: rtl/ram_sync_paged_if.sv
// Access bus of the paged RAM: {page, offset} addressing, split data buses, clear request.
interface ram_sync_paged_if
  import ram_sync_paged_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned PAGE_W = DefaultPageW,
  parameter int unsigned OFFS_W = DefaultOffsW
);

  logic                     cs;
  logic                     we;
  logic [PAGE_W-1:0]        page;
  logic [OFFS_W-1:0]        offset;
  logic [DATA_W-1:0]        wdata;
  logic                     clr_req;
  logic [DATA_W-1:0]        rdata;
  logic                     rvalid;
  logic                     busy;
  logic [PAGE_W+OFFS_W-1:0] address;

  modport master (
    output cs, we, page, offset, wdata, clr_req,
    input  rdata, rvalid, busy, address
  );

  modport slave (
    input  cs, we, page, offset, wdata, clr_req,
    output rdata, rvalid, busy, address
  );

endinterface

// File: rtl/ram_sync_paged_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module ram_sync_paged_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Only the output register is reset so rdata comes up as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_sync_paged.sv
// Paged synchronous RAM: registered read with valid strobe and a hardware clear sweep.
module ram_sync_paged
  import ram_sync_paged_pkg::*;
#(
  parameter int unsigned       DATA_W         = DefaultDataW,
  parameter int unsigned       PAGE_W         = DefaultPageW,
  parameter int unsigned       OFFS_W         = DefaultOffsW,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = DATA_W'(DefaultClearVal)
) (
  input  logic           clk,
  input  logic           reset,
  ram_sync_paged_if.slave bus
);

  localparam int unsigned       ADDR_W     = PAGE_W + OFFS_W;
  localparam int unsigned       DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);
  localparam ram_state_e        ResetState = CLEAR_ON_RESET ? StClear : StIdle;

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rvalid_q;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] user_addr;

  assign user_addr = {bus.page, bus.offset};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ResetState;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= mem_re;
    end
  end

  // The sweep owns the write port while clearing; user accesses are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = user_addr;
    mem_wdata = bus.wdata;
    unique case (state_q)
      StIdle: begin
        mem_we = bus.cs & bus.we;
        mem_re = bus.cs & ~bus.we;
        if (bus.clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = CLEAR_VAL;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  ram_sync_paged_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (bus.rdata)
  );

  assign bus.rvalid  = rvalid_q;
  assign bus.busy    = (state_q == StClear);
  assign bus.address = user_addr;

endmodule

// File: tb/tb_ram_sync_paged.sv
// Directed vector bench for ram_sync_paged with default parameters.
module tb_ram_sync_paged;

  typedef struct {
    logic       cs;
    logic       we;
    logic [3:0] page;
    logic [7:0] offset;
    logic [3:0] wdata;
    logic       clr;
    logic       exp_rvalid;
    logic [3:0] exp_rdata;
    logic       exp_busy;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n;

  vec_t vecs[$];

  ram_sync_paged_if bus ();

  ram_sync_paged dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic we, input logic [11:0] a,
                       input logic [3:0] wd, input logic clr);
    bus.cs      = cs;
    bus.we      = we;
    bus.page    = a[11:8];
    bus.offset  = a[7:0];
    bus.wdata   = wd;
    bus.clr_req = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bus.cs      = v.cs;
    bus.we      = v.we;
    bus.page    = v.page;
    bus.offset  = v.offset;
    bus.wdata   = v.wdata;
    bus.clr_req = v.clr;
    tick();
    bus.clr_req = 1'b0;
    check({name, ".rvalid"}, 32'(bus.rvalid), 32'(v.exp_rvalid));
    check({name, ".rdata"}, 32'(bus.rdata), 32'(v.exp_rdata));
    check({name, ".busy"}, 32'(bus.busy), 32'(v.exp_busy));
  endtask

  // Counts edges until busy falls; inputs stay idle.
  task automatic sweep_len(output int cnt);
    cnt = 0;
    drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
    while (bus.busy === 1'b1 && cnt < 10000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
    reset = 1'b1;

    // Reset state
    repeat (3) tick();
    check("reset.rvalid", 32'(bus.rvalid), 32'd0);
    check("reset.rdata", 32'(bus.rdata), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    sweep_len(n);
    check("sweep_after_reset.cycles", 32'(n), 32'd4096);

    // Combinational debug address
    drive(1'b0, 1'b0, 12'h321, 4'h0, 1'b0);
    #1;
    check("address.0x321", 32'(bus.address), 32'h321);

    //                cs    we    pg    off    wd    clr   rv    rd    busy
    vecs.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'h7, 8'hA5, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'h3, 8'h21, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'h3, 8'h21, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'h0, 8'h01, 4'h1, 1'b0, 1'b0, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'h0, 8'h02, 4'h2, 1'b0, 1'b0, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'h0, 8'h03, 4'h3, 1'b0, 1'b0, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 8'h01, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 8'h02, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 8'h03, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 8'h03, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0});
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Accesses and clr_req during a sweep are ignored
    run_vec('{1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1}, "clr_start");
    n = 0;
    while (bus.busy === 1'b1 && n < 10000) begin
      if (n == 100) drive(1'b1, 1'b1, 12'h010, 4'hF, 1'b0);
      else if (n == 101) drive(1'b1, 1'b0, 12'h010, 4'h0, 1'b0);
      else if (n == 102) drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b1);
      else drive(1'b0, 1'b0, 12'h000, 4'h0, 1'b0);
      tick();
      n++;
      if (n == 101 || n == 102) begin
        check("busy_access.rvalid", 32'(bus.rvalid), 32'd0);
        check("busy_access.rdata", 32'(bus.rdata), 32'h3);
      end
    end
    check("sweep_with_clr_req.cycles", 32'(n), 32'd4096);
    run_vec('{1'b1, 1'b0, 4'h0, 8'h10, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0}, "read_0x010");

    // Reset mid-sweep restarts the sweep from word 0
    run_vec('{1'b1, 1'b1, 4'h3, 8'h21, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0}, "rewrite_0x321");
    run_vec('{1'b1, 1'b0, 4'h3, 8'h21, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0}, "reread_0x321");
    run_vec('{1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 4'hA, 1'b1}, "clr_start2");
    repeat (99) tick();
    reset = 1'b1;
    #1;
    check("mid_reset.busy", 32'(bus.busy), 32'd1);
    check("mid_reset.rdata", 32'(bus.rdata), 32'd0);
    check("mid_reset.rvalid", 32'(bus.rvalid), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    sweep_len(n);
    check("sweep_after_mid_reset.cycles", 32'(n), 32'd4096);
    run_vec('{1'b1, 1'b0, 4'h7, 8'hA5, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0}, "read_0x7a5");

    // clr_req together with an access: access completes, then the sweep runs
    run_vec('{1'b1, 1'b1, 4'hF, 8'hFF, 4'h5, 1'b1, 1'b0, 4'h0, 1'b1}, "wr_clr_0xfff");
    sweep_len(n);
    check("sweep_after_wr_clr.cycles", 32'(n), 32'd4096);
    run_vec('{1'b1, 1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0}, "read_0xfff_a");
    run_vec('{1'b1, 1'b1, 4'hF, 8'hFF, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0}, "write_0xfff");
    run_vec('{1'b1, 1'b0, 4'hF, 8'hFF, 4'h0, 1'b1, 1'b1, 4'h5, 1'b1}, "rd_clr_0xfff");
    sweep_len(n);
    check("sweep_after_rd_clr.cycles", 32'(n), 32'd4096);
    run_vec('{1'b0, 1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0}, "idle_hold_5");
    run_vec('{1'b1, 1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0}, "read_0xfff_b");
    run_vec('{1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0}, "idle_hold_0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
